// File: rtl/alu_flag_sequencer_if.sv
// rtl/alu_flag_sequencer_if.sv - command, ALU, flag and response signals of the ALU flag sequencer
interface alu_flag_sequencer_if #(
    parameter int OPW = 4
);
    logic           cmd_valid;
    logic           cmd_ready;
    logic [1:0]     cmd_type;
    logic [OPW-1:0] cmd_op;
    logic [2:0]     cmd_cond;
    logic           alu_start;
    logic [OPW-1:0] alu_op;
    logic           flag_update;
    logic           cy;
    logic           acy;
    logic           zero;
    logic           sgn;
    logic           parity;
    logic           resp_valid;
    logic           resp_ready;
    logic           resp_taken;
    logic           resp_err;
    logic           busy;

    modport master (
        output cmd_valid, cmd_type, cmd_op, cmd_cond,
        output cy, acy, zero, sgn, parity, resp_ready,
        input  cmd_ready, alu_start, alu_op, flag_update,
        input  resp_valid, resp_taken, resp_err, busy
    );

    modport slave (
        input  cmd_valid, cmd_type, cmd_op, cmd_cond,
        input  cy, acy, zero, sgn, parity, resp_ready,
        output cmd_ready, alu_start, alu_op, flag_update,
        output resp_valid, resp_taken, resp_err, busy
    );
endinterface

// File: rtl/alu_flag_sequencer.sv
// rtl/alu_flag_sequencer.sv - sequences one ALU op or flag test at a time and gates flag register updates
module alu_flag_sequencer #(
    parameter int ALU_LAT = 2,
    parameter int OPW     = 4
) (
    input logic                 clk,
    input logic                 reset,
    alu_flag_sequencer_if.slave bus
);
    typedef enum logic [2:0] {IDLE, EXEC, WB, TEST, RESP} state_t;

    localparam logic [3:0] EXEC_LOAD = 4'(ALU_LAT - 1);

    state_t         state;
    logic [3:0]     cnt;
    logic [1:0]     typ;
    logic [2:0]     cond;
    logic           alu_start_q;
    logic [OPW-1:0] alu_op_q;
    logic           flag_update_q;
    logic           resp_valid_q;
    logic           resp_taken_q;
    logic           resp_err_q;

    function automatic logic cond_eval(input logic [2:0] c, input logic cy,
                                       input logic zero, input logic sgn,
                                       input logic parity);
        case (c)
            3'b000:  return 1'b1;
            3'b001:  return zero;
            3'b010:  return !zero;
            3'b011:  return cy;
            3'b100:  return !cy;
            3'b101:  return sgn;
            3'b110:  return !sgn;
            default: return parity;
        endcase
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            cnt           <= '0;
            typ           <= '0;
            cond          <= '0;
            alu_start_q   <= 1'b0;
            alu_op_q      <= '0;
            flag_update_q <= 1'b0;
            resp_valid_q  <= 1'b0;
            resp_taken_q  <= 1'b0;
            resp_err_q    <= 1'b0;
        end else begin
            alu_start_q   <= 1'b0;
            flag_update_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.cmd_valid) begin
                        typ  <= bus.cmd_type;
                        cond <= bus.cmd_cond;
                        case (bus.cmd_type)
                            2'b00, 2'b01: begin
                                state       <= EXEC;
                                cnt         <= EXEC_LOAD;
                                alu_op_q    <= bus.cmd_op;
                                alu_start_q <= 1'b1;
                            end
                            2'b10: state <= TEST;
                            default: begin
                                state        <= RESP;
                                resp_valid_q <= 1'b1;
                                resp_err_q   <= 1'b1;
                            end
                        endcase
                    end
                end
                EXEC: begin
                    if (cnt == 4'd0) begin
                        state         <= WB;
                        // flag register latches at the end of WB, so a following test sees new flags
                        flag_update_q <= (typ == 2'b00);
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                WB: begin
                    state        <= RESP;
                    resp_valid_q <= 1'b1;
                end
                TEST: begin
                    state        <= RESP;
                    resp_valid_q <= 1'b1;
                    resp_taken_q <= cond_eval(cond, bus.cy, bus.zero, bus.sgn, bus.parity);
                end
                RESP: begin
                    if (bus.resp_ready) begin
                        state        <= IDLE;
                        resp_valid_q <= 1'b0;
                        resp_taken_q <= 1'b0;
                        resp_err_q   <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.cmd_ready   = (state == IDLE);
    assign bus.busy        = (state != IDLE);
    assign bus.alu_start   = alu_start_q;
    assign bus.alu_op      = alu_op_q;
    assign bus.flag_update = flag_update_q;
    assign bus.resp_valid  = resp_valid_q;
    assign bus.resp_taken  = resp_taken_q;
    assign bus.resp_err    = resp_err_q;
endmodule

// File: tb/tb_alu_flag_sequencer.sv
// tb/tb_alu_flag_sequencer.sv - directed self-checking bench for alu_flag_sequencer
module tb_alu_flag_sequencer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    alu_flag_sequencer_if #(.OPW(4)) bus ();

    alu_flag_sequencer #(.ALU_LAT(2), .OPW(4)) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic ref_taken(input logic [2:0] c, input logic [4:0] f);
        logic cy_b, zero_b, sgn_b, par_b;
        cy_b   = f[4];
        zero_b = f[2];
        sgn_b  = f[1];
        par_b  = f[0];
        case (c)
            3'd0: ref_taken = 1'b1;
            3'd1: ref_taken = zero_b == 1'b1;
            3'd2: ref_taken = zero_b == 1'b0;
            3'd3: ref_taken = cy_b == 1'b1;
            3'd4: ref_taken = cy_b == 1'b0;
            3'd5: ref_taken = sgn_b == 1'b1;
            3'd6: ref_taken = sgn_b == 1'b0;
            default: ref_taken = par_b == 1'b1;
        endcase
    endfunction

    task automatic set_flags(input logic [4:0] f);
        {bus.cy, bus.acy, bus.zero, bus.sgn, bus.parity} = f;
    endtask

    // Call at a negedge; returns just after the accepting edge (edge 0).
    task automatic issue(input logic [1:0] t, input logic [3:0] op, input logic [2:0] c);
        bus.cmd_valid = 1'b1;
        bus.cmd_type  = t;
        bus.cmd_op    = op;
        bus.cmd_cond  = c;
        @(posedge clk);
        #1 bus.cmd_valid = 1'b0;
    endtask

    task automatic handshake();
        bus.resp_ready = 1'b1;
        @(posedge clk);
        #1 bus.resp_ready = 1'b0;
        @(negedge clk);
    endtask

    task automatic alu_cmd(input logic [1:0] t, input string nm);
        logic exp_fu;
        exp_fu = (t == 2'b00);
        issue(t, 4'h3, 3'd0);
        @(negedge clk);
        chk({nm, " c1 alu_start"}, 32'(bus.alu_start), 32'd1);
        chk({nm, " c1 alu_op"}, 32'(bus.alu_op), 32'h3);
        chk({nm, " c1 busy/ready"}, {30'd0, bus.busy, bus.cmd_ready}, 32'b10);
        @(negedge clk);
        chk({nm, " c2 alu_start"}, 32'(bus.alu_start), 32'd0);
        chk({nm, " c2 alu_op"}, 32'(bus.alu_op), 32'h3);
        chk({nm, " c2 flag_update"}, 32'(bus.flag_update), 32'd0);
        @(negedge clk);
        chk({nm, " c3 flag_update"}, 32'(bus.flag_update), 32'(exp_fu));
        chk({nm, " c3 resp_valid"}, 32'(bus.resp_valid), 32'd0);
        @(negedge clk);
        chk({nm, " c4 resp v/t/e"}, {29'd0, bus.resp_valid, bus.resp_taken, bus.resp_err}, 32'b100);
        chk({nm, " c4 flag_update"}, 32'(bus.flag_update), 32'd0);
        handshake();
        chk({nm, " after hs"}, {30'd0, bus.resp_valid, bus.cmd_ready}, 32'b01);
    endtask

    initial begin
        bus.cmd_valid  = 1'b0;
        bus.cmd_type   = 2'b00;
        bus.cmd_op     = 4'h0;
        bus.cmd_cond   = 3'd0;
        bus.resp_ready = 1'b0;
        set_flags(5'b0);

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset ready/busy", {30'd0, bus.cmd_ready, bus.busy}, 32'b10);
        chk("reset outputs", {25'd0, bus.alu_start, bus.alu_op, bus.flag_update, bus.resp_valid},
            32'd0);
        chk("reset resp t/e", {30'd0, bus.resp_taken, bus.resp_err}, 32'd0);

        alu_cmd(2'b00, "alu00");
        alu_cmd(2'b01, "alu01");

        set_flags(5'b00100);
        issue(2'b10, 4'h0, 3'b001);
        @(negedge clk);
        chk("t001 c1 resp_valid", 32'(bus.resp_valid), 32'd0);
        @(negedge clk);
        chk("t001 c2 v/t", {30'd0, bus.resp_valid, bus.resp_taken}, 32'b11);
        handshake();
        issue(2'b10, 4'h0, 3'b011);
        repeat (2) @(negedge clk);
        chk("t011 v/t", {30'd0, bus.resp_valid, bus.resp_taken}, 32'b10);
        handshake();
        set_flags(5'b00001);
        issue(2'b10, 4'h0, 3'b111);
        repeat (2) @(negedge clk);
        chk("t111 v/t", {30'd0, bus.resp_valid, bus.resp_taken}, 32'b11);
        handshake();

        for (int c = 0; c < 8; c++) begin
            for (int f = 0; f < 32; f++) begin
                set_flags(5'(f));
                issue(2'b10, 4'h0, 3'(c));
                repeat (2) @(negedge clk);
                chk($sformatf("sweep c%0d f%0d", c, f),
                    {30'd0, bus.resp_valid, bus.resp_taken},
                    {30'd0, 1'b1, ref_taken(3'(c), 5'(f))});
                handshake();
            end
        end

        issue(2'b10, 4'h0, 3'b000);
        repeat (2) @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_type  = 2'b00;
        bus.cmd_op    = 4'h9;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk($sformatf("bp%0d v/t/ready/start", i),
                {28'd0, bus.resp_valid, bus.resp_taken, bus.cmd_ready, bus.alu_start}, 32'b1100);
        end
        bus.cmd_valid = 1'b0;
        handshake();
        chk("bp release idle", {29'd0, bus.resp_valid, bus.cmd_ready, bus.busy}, 32'b010);
        @(negedge clk);
        chk("bp ignored cmd", {30'd0, bus.busy, bus.alu_start}, 32'd0);

        issue(2'b11, 4'h0, 3'd0);
        @(negedge clk);
        chk("rsv c1 v/t/e", {29'd0, bus.resp_valid, bus.resp_taken, bus.resp_err}, 32'b101);
        chk("rsv c1 start/fu", {30'd0, bus.alu_start, bus.flag_update}, 32'd0);
        handshake();
        chk("rsv after hs", {29'd0, bus.resp_valid, bus.resp_err, bus.cmd_ready}, 32'b001);

        issue(2'b00, 4'h5, 3'd0);
        @(negedge clk);
        chk("mid-exec busy", 32'(bus.busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid-exec rst state", {29'd0, bus.busy, bus.cmd_ready, bus.alu_start}, 32'b010);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("rst hold%0d fu", i), 32'(bus.flag_update), 32'd0);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk($sformatf("post rst%0d fu/v/busy", i),
                {29'd0, bus.flag_update, bus.resp_valid, bus.busy}, 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
